random_engine_arbiter: RTL and testbench
========================================

Name: random_engine_arbiter

Overview:
- Shares one RandomEngine instance between NREQ requesters.
- Each requester submits a burst request carrying tap, seed and length.
- The arbiter grants requesters round-robin, then sequences the engine's start/stop.
- It collects the engine's serial output bits into a word and returns that word on the winning requester's response channel.
- It sits between client blocks and the RandomEngine; the engine has no other driver.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, maximum burst length in bits and response word width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_val  input  NREQ  per-requester request valid
- req_rdy  output  NREQ  per-requester request ready (one-hot grant)
- req_tap  input  NREQ*8  per-requester tap mask; slice i = [8i+7:8i]
- req_seed  input  NREQ*8  per-requester seed; slice i = [8i+7:8i]
- req_len  input  NREQ*4  per-requester burst length minus 1 (0..15 → 1..16 bits)
- resp_val  output  NREQ  per-requester response valid
- resp_rdy  input  NREQ  per-requester response ready
- resp_data  output  WIDTH  collected bits, shared by all requesters, qualified by resp_val
- eng_start  output  1  to engine start
- eng_stop  output  1  to engine stop
- eng_tap  output  8  to engine tap
- eng_seed  output  8  to engine seed
- eng_active  input  1  from engine active
- eng_out  input  1  from engine out

Behaviour:
- Engine contract:
  - A 1-cycle eng_start loads tap/seed; eng_active rises the next cycle.
  - eng_out is valid on every cycle eng_active=1.
  - A 1-cycle eng_stop drops eng_active the next cycle.
  - The engine shares clk/rst with this block.
- Reset (asynchronous, rst=1), all outputs and state as follows:
  - State=IDLE.
  - rr_ptr=0.
  - req_rdy=0, resp_val=0, resp_data=0.
  - eng_start=0, eng_stop=0, eng_tap=0, eng_seed=0.
  - Bit counter=0.
  - Reset mid-burst aborts silently: no response is issued and the engine is reset by the same rst.
- States: IDLE, START, COLLECT, DRAIN, RESP.
- IDLE:
  - grant = first i with req_val[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_rdy = one-hot(grant), combinational from req_val; req_rdy=0 in all other states.
  - On handshake: latch tap, seed, len and id=grant; clear resp_data and counter; go START.
- START:
  - eng_start=1 for exactly this cycle; go COLLECT.
- eng_tap/eng_seed:
  - Driven from the latched values from START through RESP.
  - Hold last value in IDLE.
- COLLECT, each cycle with eng_active=1:
  - resp_data[cnt] <= eng_out; cnt++.
  - The first bit captured lands in bit 0.
  - Bits above len stay 0.
  - On the cycle capturing bit index len: assert eng_stop=1 (combinational, this cycle only) and go DRAIN.
  - Cycles with eng_active=0 capture nothing (waiting for the engine to start).
- DRAIN:
  - Wait until eng_active=0, then go RESP.
  - No bits are captured.
- RESP:
  - resp_val[id]=1; resp_data is held stable.
  - On resp_rdy[id]=1: rr_ptr <= (id+1) mod NREQ; go IDLE.
  - resp_rdy on other indices is ignored.
- Latency:
  - Handshake at cycle T → eng_start at T+1 → bits captured T+2..T+1+L.
  - eng_stop at T+1+L; resp_val first high at T+3+L (L = len+1).
  - With resp_rdy held high, the next grant is possible at T+4+L.
- Round-robin:
  - rr_ptr advances only on response completion, never on grant.
  - A requester's req_val held while another is serviced is granted within NREQ-1 bursts.
- Simultaneous events:
  - req_val arriving in non-IDLE states waits; no request is lost while req_val is held.
  - A requester with a pending response may re-request; it is arbitrated normally after returning to IDLE.
- Width rule: len is 4-bit; with WIDTH=16 all encodings are legal. The counter is clog2(WIDTH)+1 bits with no wrap.

Test Plan:
- Reset mid-COLLECT (rst pulse asynchronous to clk):
  - Required: all outputs 0 immediately, state IDLE, rr_ptr=0.
  - Required: a fresh request on req 2 then completes normally.
- Single request, req 0, tap=8'hB8, seed=8'hA5, len=4'd7:
  - Required: eng_start exactly 1 cycle after the handshake; eng_stop 8 cycles later.
  - Required: resp_val[0] at T+11.
  - Required: resp_data[7:0] equals the golden LFSR model's first 8 bits (bit0 first) and resp_data[15:8]=0.
- len=0 and len=15:
  - Required: exactly 1 and 16 bits captured respectively.
  - Required: for len=0, eng_stop on the first active cycle.
- All 4 requesters hold req_val, resp_rdy tied high:
  - Required: grant order 0,1,2,3,0 with distinct seeds.
  - Required: each response matches its own seed's model.
- Backpressure, resp_rdy[1]=0 for 10 cycles:
  - Required: resp_val[1] and resp_data held stable; req_rdy=0 throughout.
  - Required: release gives completion, then req 2 is granted next.
- Engine slow start (bench model delays eng_active by 3 cycles):
  - Required: no bits captured before eng_active=1; correct data returned.

Source files
------------

// File: rtl/random_engine_arbiter.sv
// random_engine_arbiter: shares one RandomEngine between NREQ requesters.
// Requesters are granted round-robin. The engine is started with the winner's
// tap/seed, len+1 serial bits are collected into a word, and the word is
// returned on the winner's response channel.
//
// Handshakes: a request transfers on a cycle where req_val[i] && req_rdy[i].
// A response transfers on a cycle where resp_val[i] && resp_rdy[i]. A valid
// signal, once raised, holds its payload until that transfer. req_rdy is
// one-hot and only ever asserted in IDLE.
module random_engine_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_val,
    output logic [NREQ-1:0]    req_rdy,
    input  logic [NREQ*8-1:0]  req_tap,
    input  logic [NREQ*8-1:0]  req_seed,
    input  logic [NREQ*4-1:0]  req_len,
    output logic [NREQ-1:0]    resp_val,
    input  logic [NREQ-1:0]    resp_rdy,
    output logic [WIDTH-1:0]   resp_data,
    output logic               eng_start,
    output logic               eng_stop,
    output logic [7:0]         eng_tap,
    output logic [7:0]         eng_seed,
    input  logic               eng_active,
    input  logic               eng_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        COLLECT = 3'd2,
        DRAIN   = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] id_q;
    logic [7:0]    tap_q;
    logic [7:0]    seed_q;
    logic [3:0]    len_q;
    logic [CW-1:0] cnt;

    logic [NREQ-1:0] req_rot;
    logic            grant_any;
    logic [PW-1:0]   grant_off;
    logic [PW:0]     grant_sum;
    logic [PW-1:0]   grant_id;
    logic [7:0]      sel_tap;
    logic [7:0]      sel_seed;
    logic [3:0]      sel_len;
    logic            last_bit;

    // Round-robin search: rotate so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_rot   = (req_val >> rr_ptr) | (req_val << (NREQ - int'(rr_ptr)));
        grant_any = |req_rot;
        grant_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) grant_off = PW'(k);
        end
        grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        if (grant_sum >= (PW+1)'(NREQ)) grant_sum = grant_sum - (PW+1)'(NREQ);
        grant_id = grant_sum[PW-1:0];
    end

    // Select the granted requester's burst parameters.
    always_comb begin
        sel_tap  = '0;
        sel_seed = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == PW'(i)) begin
                sel_tap  = req_tap[i*8 +: 8];
                sel_seed = req_seed[i*8 +: 8];
                sel_len  = req_len[i*4 +: 4];
            end
        end
    end

    // One-hot ready in IDLE only; held low while reset is asserted.
    always_comb begin
        req_rdy = '0;
        if (state == IDLE && grant_any && !rst) req_rdy[grant_id] = 1'b1;
    end

    // Response valid on the owner's channel while waiting for its ready.
    always_comb begin
        resp_val = '0;
        if (state == RESP) resp_val[id_q] = 1'b1;
    end

    assign last_bit  = (cnt == CW'(len_q));
    assign eng_start = (state == START);
    assign eng_stop  = (state == COLLECT) && eng_active && last_bit;
    assign eng_tap   = tap_q;
    assign eng_seed  = seed_q;

    // Burst sequencer: grant, start engine, collect bits, wait for engine idle, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            tap_q     <= '0;
            seed_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        tap_q     <= sel_tap;
                        seed_q    <= sel_seed;
                        len_q     <= sel_len;
                        id_q      <= grant_id;
                        cnt       <= '0;
                        resp_data <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    state <= COLLECT;
                end
                COLLECT: begin
                    // Cycles before the engine reports active capture nothing.
                    if (eng_active) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (cnt == CW'(i)) resp_data[i] <= eng_out;
                        end
                        cnt <= cnt + 1'b1;
                        if (last_bit) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!eng_active) state <= RESP;
                end
                RESP: begin
                    // Pointer moves past the completed requester, never on grant.
                    if (resp_rdy[id_q]) begin
                        rr_ptr <= (id_q == PW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_engine_arbiter.sv
// tb_random_engine_arbiter: random and directed bursts against a behavioural
// RandomEngine and a word-level scoreboard of expected responses.
module tb_random_engine_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_val;
    logic [NREQ-1:0]    req_rdy;
    logic [NREQ*8-1:0]  req_tap;
    logic [NREQ*8-1:0]  req_seed;
    logic [NREQ*4-1:0]  req_len;
    logic [NREQ-1:0]    resp_val;
    logic [NREQ-1:0]    resp_rdy;
    logic [WIDTH-1:0]   resp_data;
    logic               eng_start;
    logic               eng_stop;
    logic [7:0]         eng_tap;
    logic [7:0]         eng_seed;
    logic               eng_active;
    logic               eng_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int slow     = 0;
    int act_count = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               id_q[$];
    int               grant_q[$];

    random_engine_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_tap    (req_tap),
        .req_seed   (req_seed),
        .req_len    (req_len),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_data  (resp_data),
        .eng_start  (eng_start),
        .eng_stop   (eng_stop),
        .eng_tap    (eng_tap),
        .eng_seed   (eng_seed),
        .eng_active (eng_active),
        .eng_out    (eng_out)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Engine's serial stream: emit bit 0, shift right, feed parity of tapped bits into bit 7.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] t);
        return {^(s & t), s[7:1]};
    endfunction

    // Expected word: first len+1 stream bits, first bit in bit 0, rest zero.
    function automatic logic [WIDTH-1:0] model(input logic [7:0] t, input logic [7:0] s, input logic [3:0] len);
        logic [7:0]       st;
        logic [WIDTH-1:0] w;
        st = s;
        w  = '0;
        for (int i = 0; i <= int'(len); i++) begin
            w[i] = st[0];
            st   = lfsr_step(st, t);
        end
        return w;
    endfunction

    // Behavioural RandomEngine with an optional start delay of 'slow' cycles
    logic [7:0] e_s;
    logic [7:0] e_tap;
    logic       e_pend;
    int         e_dly;
    logic       junk = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_active <= 1'b0;
            e_s        <= '0;
            e_tap      <= '0;
            e_pend     <= 1'b0;
            e_dly      <= 0;
        end else begin
            if (eng_start) begin
                e_s   <= eng_seed;
                e_tap <= eng_tap;
                if (slow == 0) eng_active <= 1'b1;
                else begin
                    e_pend <= 1'b1;
                    e_dly  <= slow;
                end
            end else if (e_pend) begin
                if (e_dly == 1) begin
                    eng_active <= 1'b1;
                    e_pend     <= 1'b0;
                end
                e_dly <= e_dly - 1;
            end
            if (eng_active) e_s <= lfsr_step(e_s, e_tap);
            if (eng_stop) eng_active <= 1'b0;
        end
    end

    // Noise on eng_out while the engine is inactive
    always @(negedge clk) junk <= 1'($urandom_range(0, 1));
    assign eng_out = eng_active ? e_s[0] : junk;

    // Scoreboard: expected word pushed on each grant, compared on each response transfer
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            id_q.delete();
            act_count = 0;
        end else begin
            if (eng_start) act_count = 0;
            else if (eng_active) act_count++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_val[i] && req_rdy[i]) begin
                    exp_q.push_back(model(req_tap[i*8 +: 8], req_seed[i*8 +: 8], req_len[i*4 +: 4]));
                    id_q.push_back(i);
                    grant_q.push_back(i);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (resp_val[i] && resp_rdy[i]) begin
                    check("resp_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        check("resp_id", i, id_q.pop_front());
                        check("resp_data", resp_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One burst from a lone requester, with latency and bit-count checks
    task automatic do_single(input int id, input logic [7:0] tap, input logic [7:0] seed,
                             input logic [3:0] len, input int dly);
        int t0;
        int n;
        int l;
        l    = int'(len) + 1;
        slow = dly;
        req_tap[id*8 +: 8]  = tap;
        req_seed[id*8 +: 8] = seed;
        req_len[id*4 +: 4]  = len;
        req_val[id]         = 1'b1;
        #1;
        n = 0;
        while (!req_rdy[id] && n < 50) begin step(); n++; end
        check("grant", req_rdy, 64'd1 << id);
        t0 = cyc;
        step();
        req_val[id] = 1'b0;
        check("start_lat", eng_start, 1);
        n = 0;
        while (!eng_stop && n < 60) begin step(); n++; end
        check("stop_lat", cyc - t0, 1 + l + dly);
        n = 0;
        while (!resp_val[id] && n < 60) begin step(); n++; end
        check("resp_lat", cyc - t0, 3 + l + dly);
        check("bit_count", act_count, l);
        step();
        slow = 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || resp_val != '0) && n < 300) begin step(); n++; end
        check("drain", exp_q.size(), 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stimulus sequence
    initial begin
        int n;
        logic [7:0]       t8;
        logic [7:0]       s8;
        logic [3:0]       l4;
        logic [WIDTH-1:0] hold_exp;

        rst      = 1'b1;
        req_val  = '0;
        req_tap  = '0;
        req_seed = '0;
        req_len  = '0;
        resp_rdy = '1;
        repeat (3) step();
        check("reset_outs", {req_rdy, resp_val, resp_data, eng_start, eng_stop, eng_tap, eng_seed}, 64'd0);
        rst = 1'b0;
        step();

        // Directed single burst with known tap/seed
        do_single(0, 8'hB8, 8'hA5, 4'd7, 0);
        check("model_b8_a5", model(8'hB8, 8'hA5, 4'd7), 16'h00A5 ^ 16'h0000);

        // Length boundaries
        do_single(1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'd0, 0);
        do_single(3, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'd15, 0);

        // Engine slow to start
        do_single(2, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'($urandom_range(0, 15)), 3);

        // Bring the pointer back to 0, then all four requesters contend
        do_single(3, 8'h8E, 8'h5C, 4'd3, 0);
        grant_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_tap[i*8 +: 8]  = 8'($urandom_range(1, 255));
            req_seed[i*8 +: 8] = 8'(($urandom_range(1, 63) << 2) | i);
            req_len[i*4 +: 4]  = 4'($urandom_range(0, 15));
        end
        req_val = '1;
        n = 0;
        while (grant_q.size() < 5 && n < 1000) begin step(); n++; end
        req_val = '0;
        wait_drain();
        check("rr_count", grant_q.size(), 5);
        for (int i = 0; i < 5 && i < grant_q.size(); i++) check("rr_order", grant_q[i], i % NREQ);

        // Backpressure on requester 1 while requester 2 waits
        resp_rdy[1] = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            req_tap[i*8 +: 8]  = 8'($urandom_range(1, 255));
            req_seed[i*8 +: 8] = 8'($urandom_range(1, 255));
            req_len[i*4 +: 4]  = 4'($urandom_range(0, 15));
        end
        hold_exp = model(req_tap[15:8], req_seed[15:8], req_len[7:4]);
        req_val = 4'b0110;
        #1;
        check("bp_grant", req_rdy, 4'b0010);
        step();
        req_val[1] = 1'b0;
        n = 0;
        while (!resp_val[1] && n < 60) begin step(); n++; end
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", {resp_val, req_rdy, resp_data}, {4'b0010, 4'b0000, hold_exp});
            step();
        end
        resp_rdy[1] = 1'b1;
        step();
        n = 0;
        while (req_rdy == '0 && n < 10) begin step(); n++; end
        check("bp_next", req_rdy, 4'b0100);
        step();
        req_val[2] = 1'b0;
        wait_drain();

        // Randomized single bursts
        for (int k = 0; k < 16; k++) begin
            t8 = 8'($urandom_range(1, 255));
            s8 = 8'($urandom_range(1, 255));
            l4 = 4'($urandom_range(0, 15));
            do_single($urandom_range(0, NREQ - 1), t8, s8, l4, ($urandom_range(0, 1) == 1) ? 3 : 0);
        end

        // Reset in the middle of a collect phase
        do_single(2, 8'h1D, 8'h33, 4'd2, 0);
        req_tap[31:24]  = 8'hC3;
        req_seed[31:24] = 8'h7E;
        req_len[15:12]  = 4'd15;
        req_val[3]      = 1'b1;
        #1;
        n = 0;
        while (!req_rdy[3] && n < 50) begin step(); n++; end
        step();
        req_val[3] = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {req_rdy, resp_val, resp_data, eng_start, eng_stop, eng_tap, eng_seed}, 64'd0);
        step();
        step();
        #2;
        rst = 1'b0;
        step();
        check("rst_mid_idle", {resp_val, eng_start, eng_active}, 0);
        req_tap[7:0]   = 8'h96;
        req_seed[7:0]  = 8'h4B;
        req_len[3:0]   = 4'd5;
        req_val        = 4'b1001;
        #1;
        check("rst_rr_ptr", req_rdy, 4'b0001);
        step();
        req_val = '0;
        wait_drain();
        do_single(2, 8'hE1, 8'h0F, 4'd9, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
